// File: rtl/scaler_line_reader_pkg.sv
// scaler_pkg: FSM states, RAM read latency and fixed-point constants for the scaler line reader.
// SCALER_LINE_READER_OREG_EN selects the registered-output RAM latency (LAT=2).
package scaler_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
`ifdef SCALER_LINE_READER_OREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  localparam int FRAC_BITS = 8;
  localparam int ONE_STEP = 1 << FRAC_BITS;
endpackage

// File: rtl/scaler_line_reader_fifo.sv
// scaler_skid_fifo: small circular FIFO holding returned RAM read data with an occupancy count.
module scaler_skid_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 9
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             head,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk)
    if (!rst_n) begin
      mem <= '{default: '0};
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr <= inc(wr_ptr);
      end
      if (pop) rd_ptr <= inc(rd_ptr);
      count <= count + CW'(push) - CW'(pop);
    end
  assign head = mem[rd_ptr];
endmodule

// File: rtl/scaler_line_reader.sv
// scaler_line_reader: nearest-neighbour line resampling read controller feeding a valid/ready pixel stream.
// Define SCALER_LINE_READER_OREG_EN for a line-buffer RAM with registered output (LAT=2).
module scaler_line_reader
  import scaler_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8,
  parameter int FRAC_WIDTH = 8,
  parameter int LEN_WIDTH  = 12
) (
  input  logic                             rd_clk,
  input  logic                             rd_rst_n,
  input  logic                             start,
  input  logic [ADDR_WIDTH-1:0]            base_addr,
  input  logic [ADDR_WIDTH+FRAC_WIDTH-1:0] step,
  input  logic [LEN_WIDTH-1:0]             line_len,
  output logic [ADDR_WIDTH-1:0]            rd_addr,
  input  logic [DATA_WIDTH-1:0]            rd_data,
  output logic                             m_valid,
  input  logic                             m_ready,
  output logic [DATA_WIDTH-1:0]            m_data,
  output logic                             m_last,
  output logic                             busy,
  output logic                             done
);
  localparam int AW = ADDR_WIDTH + FRAC_WIDTH;
  localparam int CW = $clog2(LAT + 2);
  state_t state, state_nx;
  logic [AW-1:0] acc, step_q;
  logic [LEN_WIDTH-1:0] len_q, issued;
  logic [LAT-1:0] pend, pend_last;
  logic [CW-1:0] fifo_count;
  logic [DATA_WIDTH:0] head;
  logic issue, pop, credit, drained;
  // A beat popped this cycle frees its slot, which keeps 1 pixel/cycle under continuous ready.
  assign pop = m_valid && m_ready;
  assign credit = $countones(pend) + int'(fifo_count) - int'(pop) <= LAT;
  assign issue = state == RUN && issued != len_q && credit;
  assign drained = pend == '0 && (fifo_count == '0 || (fifo_count == CW'(1) && pop));
  assign rd_addr = acc[AW-1:FRAC_WIDTH];
  assign m_valid = fifo_count != '0;
  assign m_data = head[DATA_WIDTH-1:0];
  assign m_last = head[DATA_WIDTH];
  always_ff @(posedge rd_clk)
    if (!rd_rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state == IDLE  ? (start ? (line_len == '0 ? DONE : RUN) : IDLE)
             : state == RUN   ? (issued == len_q ? DRAIN : RUN)
             : state == DRAIN ? (drained ? DONE : DRAIN)
             : IDLE;
    busy = state == RUN || state == DRAIN;
    done = state == DONE;
  end
  always_ff @(posedge rd_clk)
    if (!rd_rst_n) begin
      acc <= '0;
      step_q <= '0;
      len_q <= '0;
      issued <= '0;
      pend <= '0;
      pend_last <= '0;
    end else begin
      if (state == IDLE && start) begin
        acc <= {base_addr, FRAC_WIDTH'(0)};
        step_q <= step;
        len_q <= line_len;
        issued <= '0;
      end else if (issue) begin
        acc <= acc + step_q;
        issued <= issued + 1'b1;
      end
      pend <= LAT'({pend, issue});
      pend_last <= LAT'({pend_last, issue && issued == len_q - 1'b1});
    end
  scaler_skid_fifo #(.DEPTH(LAT + 1), .WIDTH(DATA_WIDTH + 1)) u_fifo (
    .clk(rd_clk),
    .rst_n(rd_rst_n),
    .push(pend[LAT-1]),
    .push_data({pend_last[LAT-1], rd_data}),
    .pop(pop),
    .head(head),
    .count(fifo_count)
  );
endmodule

// File: tb/tb_scaler_line_reader.sv
// tb_scaler_line_reader: directed scoreboard bench for scaler_line_reader with a RAM model where RAM[a] = a[7:0].
module tb_scaler_line_reader;
  import scaler_pkg::*;
  logic clk = 0, rst_n = 0, start = 0, m_ready = 1;
  logic [11:0] base_addr = '0, line_len = '0, rd_addr;
  logic [19:0] step = '0;
  logic [7:0] rd_data, m_data, r1, r2;
  logic m_valid, m_last, busy, done;
  logic [8:0] exp_q[$];
  logic [8:0] hold_d;
  bit hold_v;
  int checks, errors, beats, done_cnt, cyc, start_cyc, last_cyc, done_cyc;
  int first_cyc = -1;

  scaler_line_reader dut (
    .rd_clk(clk), .rd_rst_n(rst_n), .start(start), .base_addr(base_addr), .step(step),
    .line_len(line_len), .rd_addr(rd_addr), .rd_data(rd_data), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    r1 <= rd_addr[7:0];
    r2 <= r1;
  end
  assign rd_data = (LAT == 2) ? r2 : r1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (!rst_n) hold_v = 0;
    else begin
      if (hold_v) chk("stable", {m_valid, m_last, m_data}, {1'b1, hold_d});
      if (m_valid && first_cyc < 0) first_cyc = cyc;
      if (m_valid && m_ready) begin
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL extra_beat observed %0h expected none", {m_last, m_data});
        end
        if (exp_q.size() != 0) chk("beat", {m_last, m_data}, exp_q.pop_front());
        last_cyc = cyc;
        beats++;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      hold_v = m_valid && !m_ready;
      hold_d = {m_last, m_data};
    end
  end

  task automatic run_line(input logic [11:0] base, input logic [19:0] stp, input logic [11:0] len,
                          input bit tog, input bit poke);
    logic [19:0] a;
    int b0, d0;
    for (int i = 0; i < int'(len); i++) begin
      a = {base, 8'h00} + 20'(i) * stp;
      exp_q.push_back({i == int'(len) - 1, a[15:8]});
    end
    b0 = beats;
    d0 = done_cnt;
    @(posedge clk); #1;
    base_addr = base; step = stp; line_len = len; start = 1; first_cyc = -1;
    @(posedge clk); #1;
    start = 0;
    start_cyc = cyc;
    chk("busy_start", busy, len != 0);
    chk("rd_addr_first", rd_addr, base);
    for (int i = 0; i < 400 && done_cnt == d0; i++) begin
      start = poke && i == 3;
      if (poke && i == 3) line_len = 12'd2;
      @(posedge clk); #1;
      if (tog) m_ready = ~m_ready;
    end
    start = 0;
    m_ready = 1;
    chk("done_seen", done_cnt - d0, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("single_done", done_cnt - d0, 1);
    chk("beats", beats - b0, len);
    chk("queue_empty", exp_q.size(), 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, d0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rd_addr", rd_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1;
    run_line(12'h010, 20'(ONE_STEP), 12'd4, 0, 0);
    chk("latency", first_cyc - start_cyc, LAT + 1);
    chk("no_bubble", last_cyc - first_cyc, 3);
    chk("done_timing", done_cyc - last_cyc, 1);
    run_line(12'h020, 20'h00080, 12'd6, 0, 0);
    run_line(12'h010, 20'(ONE_STEP), 12'd8, 1, 1);
    run_line(12'hFFE, 20'(ONE_STEP), 12'd4, 0, 0);
    run_line(12'h055, 20'(ONE_STEP), 12'd0, 0, 0);
    run_line(12'h100, 20'h00300, 12'd5, 0, 0);
    run_line(12'h0A0, 20'h00000, 12'd3, 1, 0);
    b0 = beats;
    for (int i = 0; i < 8; i++) exp_q.push_back({i == 7, 8'h40 + 8'(i)});
    @(posedge clk); #1;
    base_addr = 12'h040; step = 20'(ONE_STEP); line_len = 12'd8; start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int i = 0; i < 100 && beats - b0 < 3; i++) begin
      @(posedge clk); #1;
    end
    chk("beats_before_rst", beats - b0, 3);
    rst_n = 0;
    @(posedge clk); #1;
    chk("mid_rst_rd_addr", rd_addr, 0);
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_m_data", m_data, 0);
    chk("mid_rst_m_last", m_last, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    exp_q.delete();
    d0 = done_cnt;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    repeat (6) @(posedge clk);
    #1;
    chk("no_done_after_rst", done_cnt - d0, 0);
    chk("idle_after_rst", {m_valid, busy}, 0);
    run_line(12'h080, 20'(ONE_STEP), 12'd5, 0, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
